// File: rtl/store_arbiter.sv
// Arbitrates the memory controller store port between the direct store path and
// the store buffer drain. Direct stores have priority, bounded by a starvation streak.
module store_arbiter #(
    parameter int unsigned MAX_STU_STREAK = 4,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  stu_request_i,
    input  logic [ADDR_WIDTH-1:0] stu_address_i,
    input  logic [DATA_WIDTH-1:0] stu_data_i,
    input  logic [1:0]            stu_width_i,
    output logic                  stu_done_o,
    input  logic                  buf_empty_i,
    input  logic [ADDR_WIDTH-1:0] buf_address_i,
    input  logic [DATA_WIDTH-1:0] buf_data_i,
    input  logic [1:0]            buf_width_i,
    output logic                  buf_pop_o,
    output logic                  mem_request_o,
    output logic [ADDR_WIDTH-1:0] mem_address_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    output logic [1:0]            mem_width_o,
    input  logic                  mem_done_i,
    output logic                  idle_o
);

    localparam int unsigned STREAK_W = 4;
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STU_STREAK);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SERVE_STU = 2'd1,
        SERVE_BUF = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [STREAK_W-1:0]   streak_q, streak_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [1:0]            width_q, width_d;
    logic                  force_buf;

    // State, streak and latched payload registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            streak_q <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            width_q  <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            width_q  <= width_d;
        end
    end

    // Grant decision, payload capture and handshake pulses
    always_comb begin
        state_d       = state_q;
        streak_d      = streak_q;
        addr_d        = addr_q;
        data_d        = data_q;
        width_d       = width_q;
        stu_done_o    = 1'b0;
        buf_pop_o     = 1'b0;
        mem_request_o = 1'b0;
        idle_o        = 1'b0;
        force_buf     = !buf_empty_i && (streak_q == STREAK_MAX);

        unique case (state_q)
            IDLE: begin
                idle_o = !stu_request_i && buf_empty_i;
                if (stu_request_i && !force_buf) begin
                    addr_d  = stu_address_i;
                    data_d  = stu_data_i;
                    width_d = stu_width_i;
                    state_d = SERVE_STU;
                    // Streak only counts grants that bypass a waiting buffer
                    if (buf_empty_i) begin
                        streak_d = '0;
                    end else if (streak_q != STREAK_MAX) begin
                        streak_d = streak_q + 1'b1;
                    end
                end else if (!buf_empty_i) begin
                    addr_d    = buf_address_i;
                    data_d    = buf_data_i;
                    width_d   = buf_width_i;
                    buf_pop_o = 1'b1;
                    streak_d  = '0;
                    state_d   = SERVE_BUF;
                end
            end
            SERVE_STU: begin
                mem_request_o = 1'b1;
                if (mem_done_i) begin
                    stu_done_o = 1'b1;
                    state_d    = IDLE;
                end
            end
            SERVE_BUF: begin
                mem_request_o = 1'b1;
                if (mem_done_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Combinational outputs stay low for the whole reset window
        if (!rst_n_i) begin
            stu_done_o    = 1'b0;
            buf_pop_o     = 1'b0;
            mem_request_o = 1'b0;
            idle_o        = 1'b0;
        end
    end

    assign mem_address_o = addr_q;
    assign mem_data_o    = data_q;
    assign mem_width_o   = width_q;

    a_pop_not_empty: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        buf_pop_o |-> !buf_empty_i);
    a_stu_done_pulse: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        stu_done_o |=> !stu_done_o);
    a_buf_pop_pulse: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        buf_pop_o |=> !buf_pop_o);
    a_payload_stable: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        mem_request_o && !mem_done_i |=> $stable(addr_q) && $stable(data_q) && $stable(width_q));

endmodule

// File: doc/store_arbiter.md
Name: store_arbiter

Overview:
- Shares the single memory controller store port between two requesters: the store unit's direct (non-cachable / IO) path and the store buffer drain path.
- Direct stores have priority. A streak counter bounds how long the buffer can be starved.
- Grants are sequenced through a small FSM. Each transaction's address, data and width are latched, so the memory port sees stable values until completion.

Parameters:
- MAX_STU_STREAK, 4: consecutive direct grants allowed while the buffer is non-empty before one buffer grant is forced (1..15).
- ADDR_WIDTH, 32: address width.
- DATA_WIDTH, 32: data width.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous, active-low
- stu_request_i  in  1  direct store request; held high until stu_done_o
- stu_address_i  in  ADDR_WIDTH  direct store address
- stu_data_i  in  DATA_WIDTH  direct store data
- stu_width_i  in  2  store_width_t (byte/half/word)
- stu_done_o  out  1  one-cycle pulse: direct store completed
- buf_empty_i  in  1  store buffer has no entries
- buf_address_i  in  ADDR_WIDTH  head-entry address (combinational from buffer)
- buf_data_i  in  DATA_WIDTH  head-entry data
- buf_width_i  in  2  head-entry width
- buf_pop_o  out  1  one-cycle pulse: head entry consumed
- mem_request_o  out  1  store request to memory controller
- mem_address_o  out  ADDR_WIDTH  latched address
- mem_data_o  out  DATA_WIDTH  latched data
- mem_width_o  out  2  latched width
- mem_done_i  in  1  memory controller store complete (single-cycle pulse)
- idle_o  out  1  FSM in IDLE and no request pending

Behaviour:
- Reset values: all outputs 0, mem_* payload registers 0, streak counter 0, state IDLE.
- Reset asserted mid-transaction: the transaction is abandoned with no done/pop pulse. The store unit reissues; an already-popped buffer entry is lost (the core flushes on reset anyway).
- States: IDLE, SERVE_STU, SERVE_BUF.
- IDLE:
  - idle_o = !stu_request_i & buf_empty_i.
  - Grant decision is made the same cycle, and the payload is latched on the clock edge.
  - force_buf = !buf_empty_i & (streak == MAX_STU_STREAK).
  - stu_request_i & !force_buf -> latch stu_* -> SERVE_STU.
    - streak increments if !buf_empty_i (saturating at MAX_STU_STREAK); otherwise it clears.
  - else !buf_empty_i -> latch buf_*, buf_pop_o = 1 this cycle -> SERVE_BUF; streak cleared.
  - else stay IDLE.
- SERVE_STU / SERVE_BUF:
  - mem_request_o = 1 and the payload is held constant.
  - On mem_done_i: mem_request_o stays 1 in that cycle (combinational from state) and the next state is IDLE.
  - In SERVE_STU, the done cycle also drives stu_done_o = 1.
  - mem_request_o is 0 in the cycle after done.
- Latency:
  - Request seen in IDLE at cycle t -> mem_request_o high at t+1.
  - Done at cycle d -> next grant possible at d+1 (IDLE cycle) -> mem_request_o at d+2. No back-to-back without an IDLE cycle.
- mem_done_i in IDLE is ignored (no pulses, no state change).
- Request changes during SERVE_* do not disturb the latched payload. A new stu_request_i is evaluated only in IDLE.
- Simultaneous stu_request_i and !buf_empty_i with streak < MAX: direct store wins.
- stu_request_i deasserted by the requester before done is illegal. Behaviour is defined anyway: the transaction still completes and stu_done_o still pulses.
- Store buffer must present head data combinationally while !buf_empty_i. buf_pop_o is never asserted when buf_empty_i = 1.
- Assertions:
  - buf_pop_o |-> !buf_empty_i
  - stu_done_o and buf_pop_o are one cycle wide
  - mem_request_o & !mem_done_i |=> mem payload stable

Test Plan:
- Direct store only: stu addr 0x0000_1004, data 0xDEAD_BEEF, width word; mem_done_i 3 cycles after mem_request_o rises -> mem_address_o 0x1004, mem_data_o 0xDEADBEEF; stu_done_o pulses once with done; buf_pop_o never asserted.
- Buffer drain: buffer with 2 entries (0x8000_0000/0x11, 0x8000_0004/0x22), no direct requests -> two buf_pop_o pulses; mem_data_o 0x11 then 0x22; one IDLE cycle between them; idle_o = 1 after the second done once buf_empty_i is high.
- Simultaneous request at cycle 0 with buffer non-empty, streak 0 -> direct granted first (mem_address_o = stu address); buffer granted in the IDLE cycle after stu done.
- Starvation, MAX_STU_STREAK = 4: stu_request_i continuously high, buffer non-empty -> grant order STU, STU, STU, STU, BUF, STU...; exactly one buf_pop_o per 5 grants.
- Spurious mem_done_i in IDLE and stu payload changed mid-SERVE_STU -> no state change in IDLE; mem_address_o/mem_data_o keep the original latched values until done.
- Reset asserted asynchronously mid-SERVE_BUF (between clock edges) -> mem_request_o drops immediately; state IDLE; no stu_done_o or buf_pop_o pulse; normal operation resumes after reset release.
